// File: rtl/vga_fb_scheduler_pkg.sv
// Shared constants, state/grant encodings and the row-base address helper for the
// framebuffer time-slot scheduler.
package vga_fb_scheduler_pkg;

    localparam int ADDR_W      = 15;
    localparam int PIX_W       = 3;
    localparam int FB_W        = 200;
    localparam int FB_H        = 150;
    localparam int SCANOUT_LAT = 3;

    localparam logic [10:0]       H_ACTIVE  = 11'd800;
    localparam logic [9:0]        V_ACTIVE  = 10'd600;
    localparam logic [ADDR_W-1:0] FB_WORDS  = 15'(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] CLR_LAST  = FB_WORDS - 15'd1;
    localparam logic [1:0]        SCAN_SLOT = 2'd0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    typedef enum logic [2:0] {
        GNT_NONE  = 3'd0,
        GNT_SCAN  = 3'd1,
        GNT_CLEAR = 3'd2,
        GNT_WR    = 3'd3,
        GNT_RD    = 3'd4
    } grant_e;

    // row * 200 built from shifts so no multiplier is inferred: 128 + 64 + 8.
    function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] row);
        logic [ADDR_W-1:0] r;
        r = {7'd0, row};
        return (r << 7) + (r << 6) + (r << 3);
    endfunction

endpackage

// File: rtl/vga_fb_scheduler_sync_delay.sv
// Fixed-depth shift register that lines sync and active flags up with the
// read-return latency of the scanout path.
module vga_fb_scheduler_sync_delay #(
    parameter int DEPTH = 3,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/vga_fb_scheduler.sv
// Shares one single-port framebuffer RAM between VGA scanout (slot 0 of every
// active 4-pixel group), the hardware clear engine and a host read/write port.
module vga_fb_scheduler
    import vga_fb_scheduler_pkg::*;
(
    input  logic              clk50,
    input  logic              rstn,
    input  logic [10:0]       hst,
    input  logic [9:0]        vst,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [PIX_W-1:0]  rd_data,
    input  logic              clr_req,
    input  logic [PIX_W-1:0]  clr_color,
    output logic              clr_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  rgb,
    output logic              hsync,
    output logic              vsync,
    output clr_state_e        dbg_state
);

    clr_state_e        state, nxt_state;
    grant_e            gnt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [PIX_W-1:0]  clr_col;
    logic              rr_rd;
    logic              active, scan, free, host_slot;
    logic              clr_go, clr_last, wr_go, rd_go;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_d1, scan_d2;
    logic              rd_p1, rd_p2, rd_oob1, rd_oob2;
    logic [PIX_W-1:0]  pix;
    logic [2:0]        dly_q;
    logic              active_d;

    assign active    = (hst < H_ACTIVE) && (vst < V_ACTIVE);
    assign scan      = active && (hst[1:0] == SCAN_SLOT);
    assign free      = !scan;
    assign scan_addr = row_base(vst[9:2]) + {6'd0, hst[10:2]};

    // Handshake: a transfer happens in the cycle where valid && ready. Ready is a
    // function of slot, active, clear state and the rr pointer only, never of
    // valid, and at most one of wr_ready/rd_ready is high in any cycle.
    assign host_slot = rstn && free && (state == ST_IDLE);
    assign wr_ready  = host_slot && !rr_rd;
    assign rd_ready  = host_slot && rr_rd;
    assign wr_go     = wr_valid && wr_ready;
    assign rd_go     = rd_valid && rd_ready;
    assign clr_go    = free && (state == ST_CLEAR);
    assign clr_last  = clr_go && (clr_cnt == CLR_LAST);

    assign clr_busy  = (state == ST_CLEAR);
    assign dbg_state = state;

    always_ff @(posedge clk50) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE:  if (clr_req)  nxt_state = ST_CLEAR;
            ST_CLEAR: if (clr_last) nxt_state = ST_IDLE;
            default:  nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt = GNT_NONE;
        if (scan)        gnt = GNT_SCAN;
        else if (clr_go) gnt = GNT_CLEAR;
        else if (wr_go)  gnt = GNT_WR;
        else if (rd_go)  gnt = GNT_RD;
    end

    always_ff @(posedge clk50) begin
        if (!rstn) begin
            clr_cnt   <= '0;
            clr_col   <= '0;
            rr_rd     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            scan_d1   <= 1'b0;
            scan_d2   <= 1'b0;
            rd_p1     <= 1'b0;
            rd_p2     <= 1'b0;
            rd_oob1   <= 1'b0;
            rd_oob2   <= 1'b0;
            pix       <= '0;
        end else begin
            if (state == ST_IDLE && clr_req) begin
                clr_cnt <= '0;
                clr_col <= clr_color;
            end else if (clr_go) begin
                clr_cnt <= clr_cnt + 15'd1;
            end

            // Pointer flips on every host-eligible slot, so a lone requester is
            // served at least every second free slot and two requesters alternate.
            if (host_slot) rr_rd <= !rr_rd;

            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (gnt)
                GNT_SCAN: begin
                    mem_en   <= 1'b1;
                    mem_addr <= scan_addr;
                end
                GNT_CLEAR: begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= clr_cnt;
                    mem_wdata <= clr_col;
                end
                GNT_WR: if (wr_addr < FB_WORDS) begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= wr_addr;
                    mem_wdata <= wr_data;
                end
                GNT_RD: if (rd_addr < FB_WORDS) begin
                    mem_en   <= 1'b1;
                    mem_addr <= rd_addr;
                end
                default: ;
            endcase

            scan_d1 <= scan;
            scan_d2 <= scan_d1;
            if (scan_d2) pix <= mem_rdata;

            rd_p1   <= rd_go;
            rd_oob1 <= rd_go && (rd_addr >= FB_WORDS);
            rd_p2   <= rd_p1;
            rd_oob2 <= rd_oob1;
        end
    end

    assign rd_data_valid = rd_p2;
    assign rd_data       = (rd_p2 && !rd_oob2) ? mem_rdata : '0;

    vga_fb_scheduler_sync_delay #(
        .DEPTH (SCANOUT_LAT),
        .W     (3)
    ) u_sync_delay (
        .clk  (clk50),
        .rstn (rstn),
        .d    ({hsync_in, vsync_in, active}),
        .q    (dly_q)
    );

    assign hsync    = dly_q[2];
    assign vsync    = dly_q[1];
    assign active_d = dly_q[0];
    assign rgb      = active_d ? pix : '0;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler: scanout vector table plus hand-written
// sequences for host handshakes, round-robin, clear and reset corner cases.
module tb_vga_fb_scheduler;
    import vga_fb_scheduler_pkg::*;

    logic        clk50 = 1'b0;
    logic        rstn;
    logic [10:0] hst;
    logic [9:0]  vst;
    logic        hsync_in, vsync_in;
    logic        wr_valid, wr_ready;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic        rd_valid, rd_ready;
    logic [14:0] rd_addr;
    logic        rd_data_valid;
    logic [2:0]  rd_data;
    logic        clr_req;
    logic [2:0]  clr_color;
    logic        clr_busy;
    logic        mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata = 3'd0;
    logic [2:0]  rgb;
    logic        hsync, vsync;
    clr_state_e  dbg_state;

    logic [2:0]  ram [30000];
    int          oob_access = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [2:0]  exp_q [$];

    typedef struct {
        logic [10:0] hst;
        logic        hs;
        logic        vs;
        logic [2:0]  exp_rgb;
        logic        exp_hs;
        logic        exp_vs;
    } vec_t;
    vec_t vecs [16];

    always #10 clk50 = ~clk50;

    vga_fb_scheduler dut (
        .clk50         (clk50),
        .rstn          (rstn),
        .hst           (hst),
        .vst           (vst),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .clr_req       (clr_req),
        .clr_color     (clr_color),
        .clr_busy      (clr_busy),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .rgb           (rgb),
        .hsync         (hsync),
        .vsync         (vsync),
        .dbg_state     (dbg_state)
    );

    // Single-port RAM with one cycle of read latency.
    always @(posedge clk50) begin
        if (mem_en) begin
            if (mem_addr >= 15'd30000) oob_access <= oob_access + 1;
            else if (mem_we)          ram[mem_addr] <= mem_wdata;
            else                      mem_rdata <= ram[mem_addr];
        end
    end

    task automatic cyc();
        @(posedge clk50);
        #1;
    endtask

    task automatic smp();
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic host_op(input bit is_rd, input logic [14:0] addr, input logic [2:0] data,
                           output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8 && !ok; k++) begin
            cyc();
            wr_valid = !is_rd;
            rd_valid = is_rd;
            wr_addr  = addr;
            wr_data  = data;
            rd_addr  = addr;
            smp();
            if (is_rd ? rd_ready : wr_ready) ok = 1'b1;
        end
        cyc();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    initial begin
        bit         ok, wr_done, pend;
        bit         a1, a2, ready_seen;
        int         n_wr, n_rd, busy_cycles, bad_words;

        for (int i = 0; i < 30000; i++) ram[i] = 3'd0;
        ram[0] = 3'b101;
        ram[1] = 3'b010;

        vecs[0]  = '{11'd0,    1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{11'd1,    1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{11'd2,    1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{11'd3,    1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
        vecs[4]  = '{11'd4,    1'b1, 1'b0, 3'd5, 1'b0, 1'b1};
        vecs[5]  = '{11'd5,    1'b0, 1'b0, 3'd5, 1'b1, 1'b1};
        vecs[6]  = '{11'd6,    1'b0, 1'b1, 3'd5, 1'b0, 1'b0};
        vecs[7]  = '{11'd7,    1'b1, 1'b1, 3'd2, 1'b1, 1'b0};
        vecs[8]  = '{11'd800,  1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[9]  = '{11'd801,  1'b1, 1'b0, 3'd2, 1'b0, 1'b1};
        vecs[10] = '{11'd802,  1'b0, 1'b0, 3'd2, 1'b1, 1'b1};
        vecs[11] = '{11'd803,  1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[12] = '{11'd1039, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0};
        vecs[13] = '{11'd1000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[14] = '{11'd1000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[15] = '{11'd1000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};

        rstn = 1'b0; hst = 11'd900; vst = 10'd0; hsync_in = 1'b0; vsync_in = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0; clr_req = 1'b0; clr_color = '0;

        // Reset state
        for (int i = 0; i < 3; i++) cyc();
        smp();
        check("rst_rgb",      32'(rgb), 0);
        check("rst_hsync",    32'(hsync), 0);
        check("rst_vsync",    32'(vsync), 0);
        check("rst_mem_en",   32'(mem_en), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_rd_ready", 32'(rd_ready), 0);
        check("rst_clr_busy", 32'(clr_busy), 0);
        check("rst_rd_dv",    32'(rd_data_valid), 0);
        check("rst_state",    32'(dbg_state), 32'(ST_IDLE));
        cyc();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) cyc();

        // Scanout vector table
        for (int i = 0; i < 16; i++) begin
            cyc();
            hst = vecs[i].hst; hsync_in = vecs[i].hs; vsync_in = vecs[i].vs;
            smp();
            check($sformatf("vec%0d_rgb", i),   32'(rgb),   32'(vecs[i].exp_rgb));
            check($sformatf("vec%0d_hsync", i), 32'(hsync), 32'(vecs[i].exp_hs));
            check($sformatf("vec%0d_vsync", i), 32'(vsync), 32'(vecs[i].exp_vs));
        end
        hsync_in = 1'b0; vsync_in = 1'b0;

        // Host write held during an active line never sees ready in slot 0
        wr_done = 1'b0; pend = 1'b0;
        wr_addr = 15'd201; wr_data = 3'b111;
        for (int k = 0; k < 16; k++) begin
            cyc();
            hst = 11'(k); vst = 10'd4;
            wr_valid = !wr_done;
            smp();
            if (k % 4 == 0) check($sformatf("wr_ready_slot0_h%0d", k), 32'(wr_ready), 0);
            if (pend) begin
                check("wr_mem_issue", {13'd0, mem_en, mem_we, mem_addr, mem_wdata},
                      {13'd0, 1'b1, 1'b1, 15'd201, 3'b111});
                pend = 1'b0;
            end
            if (wr_valid && wr_ready) begin
                wr_done = 1'b1;
                pend = 1'b1;
            end
        end
        wr_valid = 1'b0;
        check("wr_accepted", 32'(wr_done), 1);

        // Next frame: screen pixel (4,4) lies in block 201
        cyc(); hst = 11'd4; vst = 10'd4;
        cyc(); hst = 11'd900;
        cyc();
        cyc(); smp();
        check("pix_4_4", 32'(rgb), 32'(3'b111));

        // Both host requesters held for 8 free slots
        wr_addr = 15'd5; wr_data = 3'd3; rd_addr = 15'd201; hst = 11'd900;
        n_wr = 0; n_rd = 0; a1 = 1'b0; a2 = 1'b0;
        for (int k = 0; k < 11; k++) begin
            cyc();
            wr_valid = (k < 8);
            rd_valid = (k < 8);
            smp();
            if (k < 8) check($sformatf("rr_one_ready%0d", k), 32'(wr_ready ^ rd_ready), 1);
            if (wr_valid && wr_ready) n_wr++;
            if (rd_valid && rd_ready) begin
                n_rd++;
                exp_q.push_back(3'b111);
            end
            check($sformatf("rd_dv_lat%0d", k), 32'(rd_data_valid), 32'(a2));
            if (rd_data_valid) begin
                if (exp_q.size() > 0) check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                else                  check("rd_data_unexpected", 32'(rd_data_valid), 0);
            end
            a2 = a1;
            a1 = rd_valid && rd_ready;
        end
        check("rr_wr_grants", 32'(n_wr), 4);
        check("rr_rd_grants", 32'(n_rd), 4);
        check("rd_queue_empty", 32'(exp_q.size()), 0);

        // Full clear with colour 001, all slots free
        cyc();
        clr_req = 1'b1; clr_color = 3'b001;
        busy_cycles = 0; ready_seen = 1'b0; ok = 1'b0;
        for (int n = 0; n < 40000; n++) begin
            cyc();
            clr_req   = (n == 100);
            clr_color = (n == 100) ? 3'b111 : 3'b001;
            smp();
            if (!clr_busy) begin
                ok = 1'b1;
                break;
            end
            busy_cycles++;
            if (wr_ready || rd_ready) ready_seen = 1'b1;
        end
        clr_req = 1'b0;
        check("clr_done", 32'(ok), 1);
        check("clr_busy_cycles", 32'(busy_cycles), 30000);
        check("clr_ready_blocked", 32'(ready_seen), 0);
        check("clr_ready_back", 32'(wr_ready | rd_ready), 1);
        cyc();
        cyc();
        bad_words = 0;
        for (int i = 0; i < 30000; i++) if (ram[i] !== 3'b001) bad_words++;
        check("clr_words", 32'(bad_words), 0);

        // Reset in the middle of a clear
        cyc();
        clr_req = 1'b1; clr_color = 3'b110; hst = 11'd0; vst = 10'd0;
        for (int k = 1; k < 100; k++) begin
            cyc();
            clr_req = 1'b0; hst = 11'(k);
        end
        cyc();
        rstn = 1'b0; hst = 11'd101;
        smp();
        check("rst_mid_wr_ready", 32'(wr_ready), 0);
        cyc();
        rstn = 1'b1; hst = 11'd102;
        smp();
        check("rst_mid_clr_busy", 32'(clr_busy), 0);
        check("rst_mid_rgb",      32'(rgb), 0);
        check("rst_mid_mem_en",   32'(mem_en), 0);
        check("rst_mid_state",    32'(dbg_state), 32'(ST_IDLE));

        // Out-of-range host accesses
        hst = 11'd900;
        cyc();
        host_op(1'b0, 15'd30000, 3'b111, ok);
        smp();
        check("wr_oob_accepted", 32'(ok), 1);
        check("wr_oob_no_mem",   32'(mem_en), 0);
        host_op(1'b1, 15'd30005, 3'd0, ok);
        smp();
        check("rd_oob_accepted", 32'(ok), 1);
        check("rd_oob_no_mem",   32'(mem_en), 0);
        cyc();
        smp();
        check("rd_oob_dv",   32'(rd_data_valid), 1);
        check("rd_oob_data", 32'(rd_data), 0);

        cyc();
        check("ram_oob_access", 32'(oob_access), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
